// File: rtl/expr_pipe_eval.sv
// Pipelined evaluator for a selectable Verilog expression with context-width semantics.
// The expression is resolved at entry; the slots carry the finished result and flag.
module expr_pipe_eval #(
    parameter int unsigned AW       = 6,
    parameter int unsigned BW       = 6,
    parameter int unsigned OW       = 6,
    parameter bit          A_SIGNED = 1'b1,
    parameter bit          B_SIGNED = 1'b1,
    parameter int unsigned STAGES   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] y,
    output logic          flag,
    output logic [15:0]   cnt
);

    localparam int unsigned CW_AB = (AW > BW) ? AW : BW;
    localparam int unsigned CW    = (CW_AB > OW) ? CW_AB : OW;
    localparam int unsigned BX    = (BW > 32) ? BW : 32;
    localparam bit          SCTX  = A_SIGNED && B_SIGNED;

    logic [CW-1:0] a_sx, a_zx, b_sx, b_zx;
    logic [CW-1:0] ax, bx, ash;
    logic          b_big;
    logic [CW-1:0] res_r;
    logic          res_f;
    logic [OW-1:0] res_y;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] flg_q, flg_d;
    logic [OW-1:0]     dat_q [STAGES];
    logic [OW-1:0]     dat_d [STAGES];
    logic [STAGES-1:0] adv;
    logic [15:0]       cnt_q, cnt_d;
    logic              accept;

    // Operand extension: shared context for most ops, a's own signedness for shifts
    assign a_sx  = CW'($signed(a));
    assign a_zx  = CW'(a);
    assign b_sx  = CW'($signed(b));
    assign b_zx  = CW'(b);
    assign ax    = SCTX ? a_sx : a_zx;
    assign bx    = SCTX ? b_sx : b_zx;
    assign ash   = A_SIGNED ? a_sx : a_zx;
    assign b_big = (BX'(b) >= BX'(CW));

    // Expression evaluation in the CW-bit context
    always_comb begin
        res_r = '0;
        res_f = 1'b0;
        case (op)
            4'd0:  res_r = ax + bx;
            4'd1:  res_r = ax - bx;
            4'd2:  res_r = ax * bx;
            4'd3:  res_r = ax & bx;
            4'd4:  res_r = ax | bx;
            4'd5:  res_r = ax ^ bx;
            4'd6:  res_r = ax ~^ bx;
            4'd7: begin
                if (SCTX) res_r = CW'($signed(ax) < $signed(bx));
                else      res_r = CW'(ax < bx);
            end
            4'd8: begin
                if (SCTX) res_r = CW'($signed(ax) >= $signed(bx));
                else      res_r = CW'(ax >= bx);
            end
            4'd9:  res_r = CW'(ax == bx);
            4'd10: begin
                if (!b_big) res_r = ash << b;
            end
            4'd11: begin
                if (b_big)         res_r = (A_SIGNED && ash[CW-1]) ? '1 : '0;
                else if (A_SIGNED) res_r = $signed(ash) >>> b;
                else               res_r = ash >> b;
            end
            4'd12: res_r = CW'(&a);
            4'd13: res_r = CW'(^a);
            4'd14: begin
                if (bx == '0)  res_f = 1'b1;
                else if (SCTX) res_r = $signed(ax) / $signed(bx);
                else           res_r = ax / bx;
            end
            default: begin
                if (bx == '0)  res_f = 1'b1;
                else if (SCTX) res_r = $signed(ax) % $signed(bx);
                else           res_r = ax % bx;
            end
        endcase
    end

    assign res_y = res_r[OW-1:0];

    // Slot advance: a slot moves if any slot above it is empty, or the whole tail drains
    always_comb begin
        logic full_above;
        full_above = 1'b1;
        adv        = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            adv[i]     = vld_q[i] && (out_ready || !full_above);
            full_above = full_above && vld_q[i];
        end
    end

    assign in_ready = !vld_q[0] || adv[0];
    assign accept   = in_valid && in_ready;

    // Next-state for slots and the consumed-result counter
    always_comb begin
        vld_d    = vld_q;
        flg_d    = flg_q;
        dat_d    = dat_q;
        cnt_d    = cnt_q;
        vld_d[0] = accept || (vld_q[0] && !adv[0]);
        if (accept) begin
            dat_d[0] = res_y;
            flg_d[0] = res_f;
        end
        for (int i = 1; i < int'(STAGES); i++) begin
            vld_d[i] = adv[i-1] || (vld_q[i] && !adv[i]);
            if (adv[i-1]) begin
                dat_d[i] = dat_q[i-1];
                flg_d[i] = flg_q[i-1];
            end
        end
        if (out_valid && out_ready) cnt_d = cnt_q + 16'd1;
    end

    // State registers with synchronous reset discarding all in-flight work
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            flg_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) dat_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            flg_q <= flg_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < int'(STAGES); i++) dat_q[i] <= dat_d[i];
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign y         = dat_q[STAGES-1];
    assign flag      = flg_q[STAGES-1];
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_expr_pipe_eval.sv
// Bench for expr_pipe_eval: signed-a and unsigned-a instances side by side,
// checked against an integer-arithmetic model of the expression rules.
module tb_expr_pipe_eval;

    localparam int unsigned AW = 6;
    localparam int unsigned BW = 6;
    localparam int unsigned OW = 6;
    localparam int unsigned CW = 6;
    localparam int unsigned STAGES = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic [3:0]    op;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          in_ready, out_valid, flag;
    logic [OW-1:0] y;
    logic [15:0]   cnt;
    logic          u_in_ready, u_out_valid, u_flag;
    logic [OW-1:0] u_y;
    logic [15:0]   u_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [OW-1:0] y;
        logic          f;
        logic [OW-1:0] uy;
        logic          uf;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    expr_pipe_eval #(.AW(AW), .BW(BW), .OW(OW), .A_SIGNED(1'b1), .B_SIGNED(1'b1), .STAGES(STAGES)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .flag(flag), .cnt(cnt)
    );

    expr_pipe_eval #(.AW(AW), .BW(BW), .OW(OW), .A_SIGNED(1'b0), .B_SIGNED(1'b1), .STAGES(STAGES)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .op(op), .a(a), .b(b),
        .out_valid(u_out_valid), .out_ready(out_ready), .y(u_y), .flag(u_flag), .cnt(u_cnt)
    );

    // Numeric model: operands as true integers, result reduced modulo 2^OW
    function automatic logic [OW:0] model(input logic [3:0] om, input logic [AW-1:0] am,
                                         input logic [BW-1:0] bm, input bit asg, input bit bsg);
        longint sa, sb, va, vb, r;
        logic   f;
        f  = 1'b0;
        r  = 0;
        sa = asg ? (longint'(am) - (am[AW-1] ? (longint'(1) << AW) : 0)) : longint'(am);
        sb = bsg ? (longint'(bm) - (bm[BW-1] ? (longint'(1) << BW) : 0)) : longint'(bm);
        va = (asg && bsg) ? sa : longint'(am);
        vb = (asg && bsg) ? sb : longint'(bm);
        case (om)
            4'd0:  r = va + vb;
            4'd1:  r = va - vb;
            4'd2:  r = va * vb;
            4'd3:  r = va & vb;
            4'd4:  r = va | vb;
            4'd5:  r = va ^ vb;
            4'd6:  r = ~(va ^ vb);
            4'd7:  r = (va < vb) ? 1 : 0;
            4'd8:  r = (va >= vb) ? 1 : 0;
            4'd9:  r = (va == vb) ? 1 : 0;
            4'd10: r = (int'(bm) >= int'(CW)) ? 0 : (sa << bm);
            4'd11: r = (int'(bm) >= int'(CW)) ? ((sa < 0) ? -1 : 0) : (sa >>> bm);
            4'd12: r = (am == {AW{1'b1}}) ? 1 : 0;
            4'd13: r = $countones(am) % 2;
            4'd14: if (vb == 0) f = 1'b1; else r = va / vb;
            default: if (vb == 0) f = 1'b1; else r = va % vb;
        endcase
        return {f, OW'(r)};
    endfunction

    function automatic exp_t expect_of(input logic [3:0] om, input logic [AW-1:0] am, input logic [BW-1:0] bm);
        logic [OW:0] s, u;
        s = model(om, am, bm, 1'b1, 1'b1);
        u = model(om, am, bm, 1'b0, 1'b1);
        return '{y: s[OW-1:0], f: s[OW], uy: u[OW-1:0], uf: u[OW]};
    endfunction

    // Drives one transaction into an idle pipe and waits for its result (no checking here)
    task automatic send_one(input logic [3:0] o, input logic [AW-1:0] av, input logic [BW-1:0] bv,
                            output logic [OW-1:0] ry, output logic rf, output logic [OW-1:0] ruy,
                            output int lat);
        @(negedge clk);
        op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        ry = y; rf = flag; ruy = u_y;
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (y !== '0) begin failures++; $display("FAIL reset_y got=%h exp=00", y); end
        checks++; if (flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", flag); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [3:0]    ops [8] = '{4'd0, 4'd1, 4'd7, 4'd11, 4'd10, 4'd14, 4'd15, 4'd14};
        logic [AW-1:0] as_ [8] = '{6'd31, 6'd0, 6'h3F, 6'h30, 6'd1, 6'h39, 6'h39, 6'h39};
        logic [BW-1:0] bs_ [8] = '{6'd1, 6'd1, 6'd1, 6'd2, 6'd6, 6'd2, 6'd2, 6'd0};
        logic [OW-1:0] ey  [8] = '{6'h20, 6'h3F, 6'h01, 6'h3C, 6'h00, 6'h3D, 6'h3F, 6'h00};
        logic          ef  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [OW-1:0] euy [8] = '{6'h20, 6'h3F, 6'h00, 6'h0C, 6'h00, 6'h1C, 6'h01, 6'h00};
        logic [OW-1:0] ry, ruy;
        logic          rf;
        int            lat;
        for (int i = 0; i < 8; i++) begin
            send_one(ops[i], as_[i], bs_[i], ry, rf, ruy, lat);
            checks++; if (lat != int'(STAGES)) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, STAGES); end
            checks++; if (ry !== ey[i]) begin failures++; $display("FAIL dir%0d_y op=%0d got=%h exp=%h", i, ops[i], ry, ey[i]); end
            checks++; if (rf !== ef[i]) begin failures++; $display("FAIL dir%0d_flag got=%b exp=%b", i, rf, ef[i]); end
            checks++; if (ruy !== euy[i]) begin failures++; $display("FAIL dir%0d_unsigned_y op=%0d got=%h exp=%h", i, ops[i], ruy, euy[i]); end
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 10;
        int   pops = 0;
        int   first = -1;
        exp_t e;
        q.delete();
        for (int k = 0; k < N + int'(STAGES) + 4; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (k < N);
            op = 4'($urandom); a = 6'($urandom); b = 6'($urandom);
            #1;
            if (in_valid) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, in_ready); end
            end
            if (in_valid && in_ready) q.push_back(expect_of(op, a, b));
            if (out_valid && out_ready) begin
                if (first < 0) first = k;
                pops++;
                e = (q.size() > 0) ? q.pop_front() : '0;
                checks++; if (y !== e.y || flag !== e.f) begin failures++; $display("FAIL b2b_result k=%0d got=%h/%b exp=%h/%b", k, y, flag, e.y, e.f); end
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (pops != N) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", pops, N); end
        checks++; if (first != int'(STAGES)) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", first, STAGES); end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] vals [3] = '{6'd10, 6'd20, 6'd30};
        int            sent = 0;
        int            pops = 0;
        logic [15:0]   base;
        logic [OW-1:0] held_y;
        exp_t          e;
        q.delete();
        @(negedge clk);
        base = cnt;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; op = 4'd0; b = 6'd1; a = vals[sent];
            #1;
            if (c >= 2) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full c=%0d got=%b exp=0", c, in_ready); end
                checks++; if (out_valid !== 1'b1 || y !== held_y) begin failures++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, out_valid, y, held_y); end
            end
            if (in_ready) begin q.push_back(expect_of(op, a, b)); sent++; end
            if (c == 1) held_y = q[0].y;
            @(posedge clk);
        end
        for (int c = 0; c < 20 && pops < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = (sent < 3);
            if (sent < 3) a = vals[sent];
            #1;
            if (c == 0) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept_while_full got=%b exp=1", in_ready); end
            end
            if (in_valid && in_ready) begin q.push_back(expect_of(op, a, b)); sent++; end
            if (out_valid && out_ready) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                checks++; if (y !== e.y) begin failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", pops, y, e.y); end
                pops++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (pops != 3) begin failures++; $display("FAIL bp_results got=%0d exp=3", pops); end
        checks++; if (cnt !== base + 16'd3) begin failures++; $display("FAIL bp_cnt got=%0d exp=%0d", cnt, base + 16'd3); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_duplicate got=%b exp=0", out_valid); end
    endtask

    task automatic test_mid_reset();
        logic [OW-1:0] ry, ruy;
        logic          rf;
        int            lat;
        int            stale = 0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op = 4'd0; a = 6'd5; b = 6'd6;
        @(posedge clk);
        @(negedge clk);
        a = 6'd7;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; a = 6'd9;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL mrst_cnt got=%0d exp=0", cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mrst_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL mrst_stale got=%0d exp=0", stale); end
        send_one(4'd2, 6'h3E, 6'd3, ry, rf, ruy, lat);
        checks++; if (ry !== 6'h3A || lat != int'(STAGES)) begin failures++; $display("FAIL mrst_after got=%h lat=%0d exp=3a lat=%0d", ry, lat, STAGES); end
    endtask

    task automatic test_random();
        int            pops = 0;
        logic          prev_hold = 1'b0;
        logic [OW-1:0] prev_y = '0;
        logic          prev_f = 1'b0;
        logic [15:0]   base;
        exp_t          e;
        q.delete();
        @(negedge clk);
        base = cnt;
        for (int k = 0; k < 700; k++) begin
            if (k > 0) @(negedge clk);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            op = 4'($urandom); a = 6'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            #1;
            if (prev_hold) begin
                checks++; if (out_valid !== 1'b1 || y !== prev_y || flag !== prev_f) begin failures++; $display("FAIL rnd_hold k=%0d got=%b/%h/%b exp=1/%h/%b", k, out_valid, y, flag, prev_y, prev_f); end
            end
            if (in_valid && in_ready) q.push_back(expect_of(op, a, b));
            if (out_valid && out_ready) begin
                pops++;
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rnd_spurious k=%0d got=%h exp=none", k, y);
                end else begin
                    e = q.pop_front();
                    if (y !== e.y || flag !== e.f || u_y !== e.uy || u_flag !== e.uf) begin
                        failures++;
                        $display("FAIL rnd_result k=%0d got=%h/%b u=%h/%b exp=%h/%b u=%h/%b", k, y, flag, u_y, u_flag, e.y, e.f, e.uy, e.uf);
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_y = y; prev_f = flag;
            @(posedge clk);
        end
        for (int k = 0; k < 20 && (q.size() > 0); k++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) begin
                pops++;
                e = q.pop_front();
                checks++; if (y !== e.y || flag !== e.f || u_y !== e.uy) begin failures++; $display("FAIL rnd_drain got=%h/%b u=%h exp=%h/%b u=%h", y, flag, u_y, e.y, e.f, e.uy); end
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_lost got=%0d exp=0", q.size()); end
        checks++; if (cnt !== 16'(base + 16'(pops))) begin failures++; $display("FAIL rnd_cnt got=%0d exp=%0d", cnt, 16'(base + 16'(pops))); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
